// File: rtl/alu_mdu_pkg.sv
// Shared CPU definitions: ALU source selects, ALU opcodes and multiply/divide opcodes.
package alu_mdu_pkg;

  // Second-operand source select used by the decode stage.
  typedef enum logic [1:0] {
    ALU_SRC_RT       = 2'd0,
    ALU_SRC_IMM_SEXT = 2'd1,
    ALU_SRC_IMM_ZEXT = 2'd2,
    ALU_SRC_SHAMT    = 2'd3
  } alu_src_e;

  // ALU operation select; codes 12..15 are unused and produce zero.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // Multiply/divide operation select; code 7 behaves like NOP.
  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // Busy counter width: holds latencies up to 64.
  localparam int MD_CNT_W = 7;

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit: operand/op latch, latency counter and HI/LO registers.
//
// Start/busy handshake: a start is taken only at a rising edge where in_start=1
// and out_busy=0. MULT/MULTU/DIV/DIVU then hold out_busy high for exactly the
// op latency; HI/LO update on the last busy edge and are valid in the first
// cycle out_busy is low. MTHI/MTLO write at the start edge with no busy period.
// Any in_start seen while busy is dropped entirely.
module md_unit
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  input  logic [2:0]       in_md_op,
  input  logic             in_start,
  output logic             out_busy,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  logic [MD_CNT_W-1:0]  cnt;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q, hi_q, lo_q;

  logic                 signed_op, is_div, div_by_zero;
  logic                 a_neg, b_neg;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
  logic [WIDTH-1:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // Result datapath, driven only from the latched operands so input changes
  // during the busy window cannot disturb the result.
  always_comb begin
    signed_op   = (op_q == MD_MULT) || (op_q == MD_DIV);
    is_div      = (op_q == MD_DIV) || (op_q == MD_DIVU);
    div_by_zero = (b_q == '0);
    // Sign/zero-extend to 2*WIDTH so a single unsigned multiply yields both products.
    a_ext = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;
    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. MIN/-1 wraps back to MIN with rem 0.
    a_neg  = signed_op && a_q[WIDTH-1];
    b_neg  = signed_op && b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  // Start acceptance, latency countdown and HI/LO writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - MD_CNT_W'(1);
      if (cnt == MD_CNT_W'(1)) begin
        if (is_div) begin
          if (!div_by_zero) begin
            hi_q <= rem;
            lo_q <= quot;
          end
        end else begin
          {hi_q, lo_q} <= prod;
        end
      end
    end else if (in_start) begin
      case (in_md_op)
        MD_MULT, MD_MULTU: begin
          op_q <= in_md_op;
          a_q  <= in_opA;
          b_q  <= in_opB;
          cnt  <= MD_CNT_W'(MUL_LAT);
        end
        MD_DIV, MD_DIVU: begin
          op_q <= in_md_op;
          a_q  <= in_opA;
          b_q  <= in_opB;
          cnt  <= MD_CNT_W'(DIV_LAT);
        end
        MD_MTHI: hi_q <= in_opA;
        MD_MTLO: lo_q <= in_opA;
        default: ;
      endcase
    end
  end

  assign out_busy = (cnt != '0);
  assign out_hi   = hi_q;
  assign out_lo   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Combinational ALU plus the sequential multiply/divide unit with HI/LO.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  input  logic [3:0]       in_option,
  input  logic [2:0]       in_md_op,
  input  logic             in_start,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_busy,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sum, diff;

  assign shamt    = in_opA[SH_W-1:0];
  assign out_zero = (in_opA == in_opB);

  // ALU result and signed overflow; sums are kept at WIDTH so no carry leaks out.
  always_comb begin
    sum          = in_opA + in_opB;
    diff         = in_opA - in_opB;
    out          = '0;
    out_overflow = 1'b0;
    case (in_option)
      ALU_ADD: begin
        out          = sum;
        out_overflow = (in_opA[MSB] == in_opB[MSB]) && (sum[MSB] != in_opA[MSB]);
      end
      ALU_SUB: begin
        out          = diff;
        out_overflow = (in_opA[MSB] != in_opB[MSB]) && (diff[MSB] != in_opA[MSB]);
      end
      ALU_OR:   out = in_opA | in_opB;
      ALU_AND:  out = in_opA & in_opB;
      ALU_XOR:  out = in_opA ^ in_opB;
      ALU_NOR:  out = ~(in_opA | in_opB);
      ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(in_opA) < $signed(in_opB))};
      ALU_SLTU: out = {{(WIDTH-1){1'b0}}, (in_opA < in_opB)};
      ALU_SLL:  out = in_opB << shamt;
      ALU_SRL:  out = in_opB >> shamt;
      ALU_SRA:  out = WIDTH'($signed(in_opB) >>> shamt);
      ALU_LUI:  out = in_opB << (WIDTH / 2);
      default:  out = '0;
    endcase
  end

  md_unit #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_unit (
    .clk      (clk),
    .reset    (reset),
    .in_opA   (in_opA),
    .in_opB   (in_opB),
    .in_md_op (in_md_op),
    .in_start (in_start),
    .out_busy (out_busy),
    .out_hi   (out_hi),
    .out_lo   (out_lo)
  );

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the datapath width in bits (legal values 8..64).
REQ-002 The block SHALL take parameter MUL_LAT, default 5, as the multiply latency in cycles (legal values 1..16).
REQ-003 The block SHALL take parameter DIV_LAT, default 10, as the divide latency in cycles (legal values 1..64).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_opA  input  WIDTH  operand A (rs).
REQ-007 in_opB  input  WIDTH  operand B (rt or extended immediate).
REQ-008 in_option  input  4  ALU operation select.
REQ-009 in_md_op  input  3  multiply/divide operation select.
REQ-010 in_start  input  1  qualifies in_md_op for one cycle.
REQ-011 out  output  WIDTH  combinational ALU result.
REQ-012 out_zero  output  1  in_opA == in_opB.
REQ-013 out_overflow  output  1  signed overflow of ADD/SUB.
REQ-014 out_busy  output  1  multiply/divide operation in progress.
REQ-015 out_hi  output  WIDTH  HI register.
REQ-016 out_lo  output  WIDTH  LO register.

Function
REQ-017 ALU ops SHALL be ADD=0, SUB=1, OR=2, AND=3, XOR=4, NOR=5, SLT=6 (signed), SLTU=7, SLL=8, SRL=9, SRA=10 (shift amount = in_opA[log2(WIDTH)-1:0], shifting in_opB), LUI=11 (in_opB << WIDTH/2); codes 12..15 SHALL give out=0.
REQ-018 out, out_zero and out_overflow SHALL be purely combinational, with no latch and no carry bit leaking into out.
REQ-019 out_overflow SHALL be 1 only for ADD/SUB when the operand signs make the WIDTH-bit two's-complement result wrong; otherwise it SHALL be 0.
REQ-020 MD ops SHALL be NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7 and 0 SHALL do nothing.
REQ-021 Start rule: in_start=1 with out_busy=0 at an edge SHALL latch the operands and op; in_start while out_busy=1 SHALL be ignored completely.
REQ-022 Multiply SHALL set an internal counter to MUL_LAT, and divide SHALL set it to DIV_LAT.
REQ-023 out_busy SHALL equal (counter != 0).
REQ-024 The counter SHALL decrement by one each edge while nonzero.
REQ-025 On the 1->0 counter edge, {HI,LO} SHALL receive the 2*WIDTH product, or HI=remainder and LO=quotient.
REQ-026 Result latency SHALL be that out_busy is high for exactly LAT cycles after the start edge and new HI/LO are visible in the first cycle out_busy is low.
REQ-027 MULT/DIV SHALL treat operands as signed; MULTU/DIVU SHALL treat them as unsigned.
REQ-028 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-029 Division by zero SHALL run the full DIV_LAT and leave HI and LO unchanged.
REQ-030 Signed MIN/-1 SHALL give LO=MIN and HI=0.
REQ-031 MTHI/MTLO with in_start SHALL write in_opA to HI/LO at that edge, with no busy period, and SHALL be ignored while busy.
REQ-032 Results SHALL be computed from the latched operands; changes on in_opA/in_opB during busy SHALL NOT affect the result.
REQ-033 The consuming pipeline SHALL stall MD reads on (in_start | out_busy); the block itself SHALL provide no forwarding.

Reset
REQ-034 Reset SHALL clear HI, LO, the counter, the latched operands and the latched op to 0 immediately, so that out_busy=0.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no HI/LO write after release.
REQ-036 The first start after reset release SHALL be accepted normally.

Structure
REQ-037 ALU and MD opcode encodings SHALL live in the shared CPU definitions package/header, alongside the existing ALU source-select constants.
REQ-038 The sequential part SHALL be one sub-module, md_unit (counter, operand/op latch, HI/LO).
REQ-039 The combinational ALU SHALL remain in alu_mdu.
REQ-040 The result SHALL be computable with behavioural * and / / %; an iterative implementation is permitted provided the REQ-026 timing is exact.

Verification
REQ-041 The bench SHALL cover ADD 0x7FFFFFFF+1 -> out=0x80000000, out_overflow=1; SUB 5-5 -> out=0, out_zero=1, out_overflow=0.
REQ-042 The bench SHALL cover MULT 0xFFFFFFFF*3 -> busy exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFD.
REQ-043 The bench SHALL cover DIV -7/2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI and LO unchanged after 10 cycles.
REQ-044 The bench SHALL cover MULT in flight, then MTLO and DIVU start pulses while busy -> both ignored and the final HI/LO equal the MULT result.
REQ-045 The bench SHALL cover DIV started and reset pulsed at busy cycle 4 -> out_busy=0, HI=LO=0 immediately and unchanged through 20 further cycles.
REQ-046 The bench SHALL cover SRA with in_opA=4, in_opB=0x80000000 -> out=0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU with the same operands -> 0.
